// File: rtl/seq_hit_counter_pkg.sv
// Shared definitions for the per-frame hit counter: FSM encodings and default widths.
package seq_hit_counter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_COUNT  = 2'b01,
        S_REPORT = 2'b10
    } state_e;

    localparam int unsigned CNT_W_DEF     = 8;
    localparam int unsigned FRAME_LEN_DEF = 16;
    localparam int unsigned BIT_W_DEF     = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat latches when an increment hits the ceiling.
module sat_counter
    import seq_hit_counter_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic             at_max
);

    logic [CNT_W-1:0] r_count;
    logic             r_sat;

    assign at_max = &r_count;
    assign count  = r_count;
    assign sat    = r_sat;

    // Count qualified increments; clear has priority over inc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (inc) begin
            if (at_max) begin
                r_sat <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_hit_counter.sv
// Counts detector match pulses per frame of FRAME_LEN qualified slots and publishes the result
// through a valid/ready report port.
// Optional macro SEQ_HIT_CONTINUOUS_EN: back-to-back frames without a REPORT state, with a
// sticky rpt_drop flag for results lost to an un-drained report register.
module seq_hit_counter
    import seq_hit_counter_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned BIT_W     = BIT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             en,
    input  logic             hit,
    output logic             busy,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_sat,
    output logic             rpt_drop
);

    localparam logic [BIT_W-1:0] LastSlot = BIT_W'(FRAME_LEN - 1);

    state_e           r_state;
    logic [BIT_W-1:0] r_slot;
    logic             r_busy;
    logic             r_valid;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;

    logic             w_restart;
    logic             w_qual;
    logic             w_last;
    logic             w_clr;
    logic             w_inc;
    logic             w_accept;
    logic [CNT_W-1:0] w_hits;
    logic             w_hits_sat;
    logic             w_at_max;
    logic [CNT_W-1:0] w_hits_nxt;
    logic             w_sat_nxt;

`ifdef SEQ_HIT_CONTINUOUS_EN
    logic r_drop;

    // start only opens a frame from IDLE; frame end rolls straight into the next frame.
    assign w_restart = (r_state == S_IDLE) && start;
    assign w_clr     = w_restart || w_last;
    assign rpt_drop  = r_drop;
`else
    // start in COUNT restarts the frame and masks en for that cycle.
    assign w_restart = ((r_state == S_IDLE) || (r_state == S_COUNT)) && start;
    assign w_clr     = w_restart;
    assign rpt_drop  = 1'b0;
`endif

    assign w_qual   = (r_state == S_COUNT) && en && !w_restart;
    assign w_last   = w_qual && (r_slot == LastSlot);
    assign w_inc    = w_qual && hit;
    assign w_accept = r_valid && rpt_ready;

    // A hit in the final slot must be part of the report, so load the post-increment value.
    assign w_hits_nxt = w_hits + CNT_W'(w_inc && !w_at_max);
    assign w_sat_nxt  = w_hits_sat || (w_inc && w_at_max);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_hits (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clr),
        .inc    (w_inc),
        .count  (w_hits),
        .sat    (w_hits_sat),
        .at_max (w_at_max)
    );

    // Frame FSM, slot counter and report holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_slot  <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_count <= '0;
            r_sat   <= 1'b0;
`ifdef SEQ_HIT_CONTINUOUS_EN
            r_drop  <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_valid <= 1'b0;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_COUNT;
                        r_slot  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (w_restart) begin
                        r_slot <= '0;
                    end else if (w_qual) begin
                        if (w_last) begin
                            r_slot <= '0;
`ifdef SEQ_HIT_CONTINUOUS_EN
                            // Load if the register is empty or being drained this cycle.
                            if (!r_valid || rpt_ready) begin
                                r_valid <= 1'b1;
                                r_count <= w_hits_nxt;
                                r_sat   <= w_sat_nxt;
                            end else begin
                                r_drop  <= 1'b1;
                            end
`else
                            r_valid <= 1'b1;
                            r_count <= w_hits_nxt;
                            r_sat   <= w_sat_nxt;
                            r_state <= S_REPORT;
                            r_busy  <= 1'b0;
`endif
                        end else begin
                            r_slot <= r_slot + 1'b1;
                        end
                    end
                end
                S_REPORT: begin
                    if (w_accept) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign rpt_valid = r_valid;
    assign rpt_count = r_count;
    assign rpt_sat   = r_sat;

endmodule

// File: tb/tb_seq_hit_counter.sv
// Scoreboard bench for seq_hit_counter: an 8-bit and a 2-bit instance share stimulus; expected
// reports are queued per instance and popped by a monitor at each report handshake.
module tb_seq_hit_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       en;
    logic       hit;
    logic       rpt_ready;

    logic       busy8, valid8, sat8, drop8;
    logic [7:0] cnt8;
    logic       busy2, valid2, sat2, drop2;
    logic [1:0] cnt2;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] cnt;
        logic       sat;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];
    exp_t e8;
    exp_t e2;

    always #5 clk = ~clk;

    seq_hit_counter #(
        .CNT_W     (8),
        .FRAME_LEN (16),
        .BIT_W     (5)
    ) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .en        (en),
        .hit       (hit),
        .busy      (busy8),
        .rpt_valid (valid8),
        .rpt_ready (rpt_ready),
        .rpt_count (cnt8),
        .rpt_sat   (sat8),
        .rpt_drop  (drop8)
    );

    seq_hit_counter #(
        .CNT_W     (2),
        .FRAME_LEN (16),
        .BIT_W     (5)
    ) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .en        (en),
        .hit       (hit),
        .busy      (busy2),
        .rpt_valid (valid2),
        .rpt_ready (rpt_ready),
        .rpt_count (cnt2),
        .rpt_sat   (sat2),
        .rpt_drop  (drop2)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] c8, input logic s8, input logic [7:0] c2,
                        input logic s2);
        q8.push_back('{cnt: c8, sat: s8});
        q2.push_back('{cnt: c2, sat: s2});
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drive qualified slots first..last, hit taken from the mask bit of each slot.
    task automatic run_slots(input logic [15:0] mask, input int first, input int last);
        for (int s = first; s <= last; s++) begin
            en  = 1'b1;
            hit = mask[s];
            tick();
        end
        en  = 1'b0;
        hit = 1'b0;
    endtask

    task automatic accept;
        rpt_ready = 1'b1;
        tick();
        rpt_ready = 1'b0;
    endtask

    // Monitor: every report handshake consumes one expected entry per instance.
    always @(negedge clk) begin
        if (!reset && rpt_ready) begin
            if (valid8) begin
                n_vec++;
                if (q8.size() == 0) begin
                    n_err++;
                    $display("FAIL rpt8 unexpected: got count %0d sat %0d, none expected",
                             cnt8, sat8);
                end else begin
                    e8 = q8.pop_front();
                    if (cnt8 !== e8.cnt || sat8 !== e8.sat) begin
                        n_err++;
                        $display("FAIL rpt8: got count %0d sat %0d, expected count %0d sat %0d",
                                 cnt8, sat8, e8.cnt, e8.sat);
                    end
                end
            end
            if (valid2) begin
                n_vec++;
                if (q2.size() == 0) begin
                    n_err++;
                    $display("FAIL rpt2 unexpected: got count %0d sat %0d, none expected",
                             cnt2, sat2);
                end else begin
                    e2 = q2.pop_front();
                    if ({6'd0, cnt2} !== e2.cnt || sat2 !== e2.sat) begin
                        n_err++;
                        $display("FAIL rpt2: got count %0d sat %0d, expected count %0d sat %0d",
                                 cnt2, sat2, e2.cnt, e2.sat);
                    end
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        en        = 1'b0;
        hit       = 1'b0;
        rpt_ready = 1'b0;
        tick();
        tick();
        chk("reset busy", 32'(busy8), 0);
        chk("reset valid", 32'(valid8), 0);
        chk("reset count", 32'(cnt8), 0);
        chk("reset sat", 32'(sat8), 0);
        chk("reset drop", 32'(drop8), 0);
        reset = 1'b0;
        tick();

`ifdef SEQ_HIT_CONTINUOUS_EN
        pulse_start();
        chk("cont busy", 32'(busy8), 1);
        // Frame 1: hits on slots 0 and 9.
        run_slots(16'h0201, 0, 15);
        chk("f1 valid", 32'(valid8), 1);
        chk("f1 count", 32'(cnt8), 2);
        chk("f1 no drop", 32'(drop8), 0);
        chk("f1 still busy", 32'(busy8), 1);
        push(8'd2, 1'b0, 8'd2, 1'b0);
        // Frame 2: 5 hits, lost because the report is not drained.
        run_slots(16'h003E, 0, 15);
        chk("f2 drop8", 32'(drop8), 1);
        chk("f2 drop2", 32'(drop2), 1);
        chk("f2 count held8", 32'(cnt8), 2);
        chk("f2 count held2", 32'(cnt2), 2);
        chk("f2 valid held", 32'(valid8), 1);
        // Frame 3: 4 hits; the old report drains on the frame-end cycle.
        run_slots(16'h000F, 0, 14);
        rpt_ready = 1'b1;
        run_slots(16'h000F, 15, 15);
        rpt_ready = 1'b0;
        chk("f3 valid", 32'(valid8), 1);
        chk("f3 count8", 32'(cnt8), 4);
        chk("f3 count2", 32'(cnt2), 3);
        chk("f3 sat2", 32'(sat2), 1);
        push(8'd4, 1'b0, 8'd3, 1'b1);
        accept();
        chk("f3 drained", 32'(valid8), 0);
        chk("drop sticky", 32'(drop8), 1);
`else
        chk("drop tied", 32'(drop8), 0);

        // Frame with hits on slots 2, 5, 15.
        pulse_start();
        chk("t1 busy", 32'(busy8), 1);
        run_slots(16'h8024, 0, 14);
        chk("t1 valid early", 32'(valid8), 0);
        run_slots(16'h8024, 15, 15);
        chk("t1 valid", 32'(valid8), 1);
        chk("t1 count", 32'(cnt8), 3);
        chk("t1 sat", 32'(sat8), 0);
        chk("t1 busy off", 32'(busy8), 0);
        push(8'd3, 1'b0, 8'd3, 1'b0);

        // Back-pressure: report held stable; stray en/hit/start are ignored in REPORT.
        for (int i = 0; i < 10; i++) begin
            en    = 1'b1;
            hit   = 1'b1;
            start = (i == 4);
            tick();
            chk("t2 valid held", 32'(valid8), 1);
            chk("t2 count held", 32'(cnt8), 3);
        end
        en    = 1'b0;
        hit   = 1'b0;
        start = 1'b0;
        accept();
        chk("t2 valid drop", 32'(valid8), 0);
        chk("t2 busy", 32'(busy8), 0);

        // Hit on every slot: 2-bit instance saturates.
        pulse_start();
        run_slots(16'hFFFF, 0, 15);
        chk("t3 count2", 32'(cnt2), 3);
        chk("t3 sat2", 32'(sat2), 1);
        chk("t3 count8", 32'(cnt8), 16);
        chk("t3 sat8", 32'(sat8), 0);
        push(8'd16, 1'b0, 8'd3, 1'b1);
        accept();

        // Restart at slot 7 after 2 hits; start wins over en on the restart cycle.
        pulse_start();
        run_slots(16'h000A, 0, 6);
        start = 1'b1;
        en    = 1'b1;
        hit   = 1'b1;
        tick();
        start = 1'b0;
        chk("t4 busy", 32'(busy8), 1);
        run_slots(16'h0010, 0, 15);
        chk("t4 valid", 32'(valid8), 1);
        chk("t4 count", 32'(cnt8), 1);
        // Reset mid-report discards the pending report.
        reset = 1'b1;
        #1;
        chk("t4 rst valid", 32'(valid8), 0);
        chk("t4 rst count", 32'(cnt8), 0);
        chk("t4 rst busy", 32'(busy8), 0);
        chk("t4 rst valid2", 32'(valid2), 0);
        chk("t4 rst count2", 32'(cnt2), 0);
        tick();
        reset = 1'b0;
        tick();

        // en on alternate cycles, hit held high: only qualified slots count.
        pulse_start();
        hit = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            en = (i % 2 == 0);
            if (i == 30) chk("t5 valid early", 32'(valid8), 0);
            tick();
        end
        en  = 1'b0;
        hit = 1'b0;
        chk("t5 valid", 32'(valid8), 1);
        chk("t5 count8", 32'(cnt8), 16);
        chk("t5 count2", 32'(cnt2), 3);
        chk("t5 sat2", 32'(sat2), 1);
        push(8'd16, 1'b0, 8'd3, 1'b1);
        accept();
        chk("t5 drained", 32'(valid8), 0);
`endif

        tick();
        chk("queue8 empty", 32'(q8.size()), 0);
        chk("queue2 empty", 32'(q2.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
